// File: rtl/hit_envelope_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : hit_envelope_if
// Purpose  : Raster position, hit strobes, decay factor and per-instrument
//            intensity outputs of the hit_envelope block.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface hit_envelope_if #(
  parameter int INSTRUMENT_COUNT = 3
);
  logic [10:0]                       h_count;
  logic [9:0]                        v_count;
  logic [INSTRUMENT_COUNT-1:0]       hit_valid;
  logic [INSTRUMENT_COUNT-1:0][6:0]  hit_velocity;
  logic [9:0]                        decay;
  logic [INSTRUMENT_COUNT-1:0][7:0]  inst_intensity;

  // Stimulus / raster side
  modport master (
    output h_count, v_count, hit_valid, hit_velocity, decay,
    input  inst_intensity
  );

  // Envelope engine side
  modport slave (
    input  h_count, v_count, hit_valid, hit_velocity, decay,
    output inst_intensity
  );
endinterface
`default_nettype wire

// File: rtl/hit_envelope.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : hit_envelope
// Purpose  : Per-instrument hit envelope. Hits are collected per frame, and on
//            the frame tick each level is decayed through one shared
//            multiplier (one instrument per cycle) and then committed to the
//            outputs together. Bit 7 of each output flags a hit in that frame.
// Options  : HIT_ENVELOPE_PEAK_HOLD_EN - a hit keeps the larger of the decayed
//            level and the hit velocity instead of replacing the level.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module hit_envelope #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int TICK_V           = 720,
  parameter int TICK_H           = 0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hit_envelope_if.slave bus
);

  localparam int IDX_W = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(INSTRUMENT_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECAY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [IDX_W-1:0]                  r_idx;

  logic [6:0]                        r_pend_vel  [INSTRUMENT_COUNT];
  logic [INSTRUMENT_COUNT-1:0]       r_pend_flag;
  logic [6:0]                        r_snap_vel  [INSTRUMENT_COUNT];
  logic [INSTRUMENT_COUNT-1:0]       r_snap_flag;
  logic [6:0]                        r_level     [INSTRUMENT_COUNT];
  logic [INSTRUMENT_COUNT-1:0][7:0]  r_out;

  logic [6:0]                        w_merge_vel [INSTRUMENT_COUNT];
  logic [INSTRUMENT_COUNT-1:0]       w_merge_flag;
  logic                              w_tick;
  logic                              w_tick_accept;
  logic [14:0]                       w_product;
  logic [6:0]                        w_decayed;
  logic [6:0]                        w_next_level;
  logic                              w_unused_decay;

  // Only the upper eight bits of the decay factor feed the multiplier.
  assign w_unused_decay = ^bus.decay[1:0];

  assign w_tick        = (bus.h_count == 11'(TICK_H)) && (bus.v_count == 10'(TICK_V));
  assign w_tick_accept = w_tick && (r_state == S_IDLE);

  // Fold this cycle's hits into the pending values (running max per frame).
  always_comb begin
    w_merge_flag = r_pend_flag | bus.hit_valid;
    for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
      w_merge_vel[i] = r_pend_vel[i];
      if (bus.hit_valid[i] && (bus.hit_velocity[i] > r_pend_vel[i])) begin
        w_merge_vel[i] = bus.hit_velocity[i];
      end
    end
  end

  // Shared decay multiplier for the instrument selected by r_idx.
  assign w_product = 15'(r_level[r_idx]) * 15'(bus.decay[9:2]);
  assign w_decayed = w_product[14:8];

  // Select the new level: decayed, or overridden by this frame's hit.
  always_comb begin
    w_next_level = w_decayed;
    if (r_snap_flag[r_idx]) begin
`ifdef HIT_ENVELOPE_PEAK_HOLD_EN
      w_next_level = (r_snap_vel[r_idx] > w_decayed) ? r_snap_vel[r_idx] : w_decayed;
`else
      w_next_level = r_snap_vel[r_idx];
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: tick starts the sweep, last index leads to the commit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_state_nxt = S_DECAY;
      S_DECAY:  if (r_idx == c_LAST_IDX) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Pending capture and snapshot on an accepted tick; late ticks only collect hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_flag <= '0;
      r_snap_flag <= '0;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        r_pend_vel[i] <= '0;
        r_snap_vel[i] <= '0;
      end
    end else if (w_tick_accept) begin
      r_snap_flag <= w_merge_flag;
      r_pend_flag <= '0;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        r_snap_vel[i] <= w_merge_vel[i];
        r_pend_vel[i] <= '0;
      end
    end else begin
      r_pend_flag <= w_merge_flag;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        r_pend_vel[i] <= w_merge_vel[i];
      end
    end
  end

  // Sweep index, level updates during DECAY and the single-cycle output commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_out <= '0;
      for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
        r_level[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) r_idx <= '0;
        end
        S_DECAY: begin
          r_level[r_idx] <= w_next_level;
          if (r_idx != c_LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            r_out[i] <= {r_snap_flag[i], r_level[i]};
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign bus.inst_intensity = r_out;

endmodule
`default_nettype wire
